// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 8-bit
// datapath. Drives ALU-decoder inputs plus PC/IR/memory/register-file strobes.
module alu_sequencer #(
    parameter int CNT_W       = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             mem_ready,
    input  logic [7:0]       instr,
    input  logic             alu_zero,
    output logic [2:0]       state,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic             alu_funct,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_NAND  = 3'b001;
    localparam logic [2:0] OP_SLT   = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_LWSW  = 3'b100;
    localparam logic [2:0] OP_ADDI  = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    state_t             state_q, state_d;
    logic [1:0]         fault_q, fault_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic [2:0] op_s;
    logic       funct_s;
    logic       illegal_s;
    logic       timeout_s;
    logic       retire_s;
    state_t     boundary_s;
    logic       unused_instr_s;

    assign op_s           = instr[7:5];
    assign funct_s        = instr[0];
    assign unused_instr_s = ^instr[4:1];
    assign illegal_s      = ((op_s == OP_ADD) || (op_s == OP_NAND)) && !funct_s;
    // The limit cycle itself is the timeout cycle unless mem_ready arrives in it.
    assign timeout_s      = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_LAST);
    assign boundary_s     = halt_req ? S_IDLE : S_FETCH;

    // Next-state, sticky fault, retire pulse and the combinational strobes.
    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        retire_s  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_branch = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 3'b000;
        alu_funct = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
                else       state_d = S_IDLE;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_HALTED;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    mem_read = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_s == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (illegal_s) begin
                    state_d = S_HALTED;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_s)
                    OP_ADD, OP_NAND, OP_SLT, OP_SHIFT: begin
                        alu_op    = op_s;
                        alu_funct = funct_s;
                        state_d   = S_WB;
                    end
                    OP_ADDI: begin
                        alu_op    = OP_ADDI;
                        alu_src_b = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LWSW: begin
                        alu_op    = OP_ADDI;
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op    = OP_BEQ;
                        alu_funct = funct_s;
                        pc_write  = alu_zero;
                        pc_branch = alu_zero;
                        retire_s  = 1'b1;
                        state_d   = boundary_s;
                    end
                    default: begin
                        state_d = S_HALTED;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    mem_write = funct_s;
                    mem_read  = !funct_s;
                    if (funct_s) begin
                        retire_s = 1'b1;
                        state_d  = boundary_s;
                    end else begin
                        state_d  = S_WB;
                    end
                end else if (timeout_s) begin
                    state_d = S_HALTED;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    mem_write = funct_s;
                    mem_read  = !funct_s;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                retire_s  = 1'b1;
                state_d   = boundary_s;
            end
            S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    fault_d = FAULT_NONE;
                end else begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire_s) retired_d = retired_q + CNT_W'(1);
        else          retired_d = retired_q;

        if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
            wait_d = wait_q + WAIT_W'(1);
        else
            wait_d = '0;
    end

    // State, fault, retire counter and memory-wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            fault_q   <= FAULT_NONE;
            retired_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    assign state   = state_q;
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven, scoreboarded bench for alu_sequencer: each row is one clock
// cycle of inputs plus the outputs expected in that cycle.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, halt_req, mem_ready, alu_zero;
    logic [7:0] instr;
    logic [2:0] state, alu_op;
    logic       ir_write, pc_write, pc_branch, mem_read, mem_write, reg_write, alu_src_b, alu_funct;
    logic [1:0] fault;
    logic [7:0] retired;

    alu_sequencer #(.CNT_W(8), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .mem_ready(mem_ready), .instr(instr), .alu_zero(alu_zero),
        .state(state), .ir_write(ir_write), .pc_write(pc_write),
        .pc_branch(pc_branch), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .alu_funct(alu_funct), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] N   = 7'b0000000;
    localparam logic [6:0] IRW = 7'b1000000;
    localparam logic [6:0] PCW = 7'b0100000;
    localparam logic [6:0] PCB = 7'b0010000;
    localparam logic [6:0] MRD = 7'b0001000;
    localparam logic [6:0] MWR = 7'b0000100;
    localparam logic [6:0] RGW = 7'b0000010;
    localparam logic [6:0] SRB = 7'b0000001;
    localparam logic [6:0] FD  = IRW | PCW | MRD;

    typedef struct {
        logic       start, halt, mrdy;
        logic [7:0] ins;
        logic       az;
        logic [2:0] st;
        logic [6:0] strb;
        logic [2:0] op;
        logic       fn;
        logic [1:0] flt;
        logic       ret;
    } vec_t;

    typedef struct packed {
        logic [2:0] st;
        logic [6:0] strb;
        logic [2:0] op;
        logic       fn;
        logic [1:0] flt;
        logic [7:0] ret;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rc       = 0;
    int   vec_no   = 0;

    function automatic void add(input logic s, input logic h, input logic m, input logic [7:0] i,
                                input logic a, input logic [2:0] st, input logic [6:0] sbits,
                                input logic [2:0] op, input logic fn, input logic [1:0] f,
                                input logic r);
        vec_t v;
        v.start = s; v.halt = h; v.mrdy = m; v.ins = i; v.az = a;
        v.st = st; v.strb = sbits; v.op = op; v.fn = fn; v.flt = f; v.ret = r;
        tbl.push_back(v);
    endfunction

    // Apply every row: drive after the edge, sample mid-cycle, compare against the scoreboard.
    task automatic run_table();
        exp_t e, act;
        foreach (tbl[k]) begin
            start     = tbl[k].start;
            halt_req  = tbl[k].halt;
            mem_ready = tbl[k].mrdy;
            instr     = tbl[k].ins;
            alu_zero  = tbl[k].az;
            e.st = tbl[k].st; e.strb = tbl[k].strb; e.op = tbl[k].op;
            e.fn = tbl[k].fn; e.flt = tbl[k].flt; e.ret = 8'(rc);
            sb.push_back(e);
            @(negedge clk);
            act = {state, {ir_write, pc_write, pc_branch, mem_read, mem_write, reg_write, alu_src_b},
                   alu_op, alu_funct, fault, retired};
            e = sb.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL vec%0d: got st=%0d strb=%b op=%b fn=%b flt=%b ret=%0d, want st=%0d strb=%b op=%b fn=%b flt=%b ret=%0d",
                         vec_no, act.st, act.strb, act.op, act.fn, act.flt, act.ret,
                         e.st, e.strb, e.op, e.fn, e.flt, e.ret);
            end
            if (tbl[k].ret) rc++;
            vec_no++;
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
        instr = 8'h00; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state, then add 0x01 with mem_ready high
        add(0,0,1,8'h01,0, 3'd0,N,  3'b000,0,2'b00,0);
        add(1,0,1,8'h01,0, 3'd0,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h01,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'h01,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h01,0, 3'd3,N,  3'b000,1,2'b00,0);
        add(0,0,1,8'h01,0, 3'd5,RGW,3'b000,0,2'b00,1);
        // lw with memory stalling three cycles
        add(0,0,1,8'h80,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'h80,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h80,0, 3'd3,SRB,3'b101,0,2'b00,0);
        for (int k = 0; k < 3; k++) add(0,0,0,8'h80,0, 3'd4,MRD,3'b000,0,2'b00,0);
        add(0,0,1,8'h80,0, 3'd4,MRD,3'b000,0,2'b00,0);
        add(0,0,1,8'h80,0, 3'd5,RGW,3'b000,0,2'b00,1);
        // beq taken, then not taken
        add(0,0,1,8'hC0,1, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'hC0,1, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'hC0,1, 3'd3,PCW|PCB,3'b110,0,2'b00,1);
        add(0,0,1,8'hC0,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'hC0,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'hC0,0, 3'd3,N,  3'b110,0,2'b00,1);
        // sw
        add(0,0,1,8'h81,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'h81,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h81,0, 3'd3,SRB,3'b101,0,2'b00,0);
        add(0,0,1,8'h81,0, 3'd4,MWR,3'b000,0,2'b00,1);
        // addi with halt_req raised in EXEC: finishes WB, then IDLE and holds
        add(0,0,1,8'hA0,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'hA0,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,1,1,8'hA0,0, 3'd3,SRB,3'b101,0,2'b00,0);
        add(0,1,1,8'hA0,0, 3'd5,RGW,3'b000,0,2'b00,1);
        add(0,0,1,8'hA0,0, 3'd0,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'hA0,0, 3'd0,N,  3'b000,0,2'b00,0);
        // illegal add 0x00 -> HALTED fault 01; restart clears it; start mid-DECODE ignored
        add(1,0,1,8'h00,0, 3'd0,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h00,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'h00,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h00,0, 3'd6,N,  3'b000,0,2'b01,0);
        add(1,0,1,8'h00,0, 3'd6,N,  3'b000,0,2'b01,0);
        add(0,0,1,8'h01,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(1,0,1,8'h01,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h01,0, 3'd3,N,  3'b000,1,2'b00,0);
        add(0,0,1,8'h01,0, 3'd5,RGW,3'b000,0,2'b00,1);
        // halt opcode: HALTED without fault, then shift
        add(0,0,1,8'hE0,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'hE0,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(1,0,1,8'hE0,0, 3'd6,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h61,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'h61,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h61,0, 3'd3,N,  3'b011,1,2'b00,0);
        add(0,1,1,8'h61,0, 3'd5,RGW,3'b000,0,2'b00,1);
        // fetch timeout: 15th unready cycle drops strobes and halts with fault 10
        add(1,0,0,8'h01,0, 3'd0,N,  3'b000,0,2'b00,0);
        for (int k = 0; k < 14; k++) add(0,0,0,8'h01,0, 3'd1,MRD,3'b000,0,2'b00,0);
        add(0,0,0,8'h01,0, 3'd1,N,  3'b000,0,2'b00,0);
        add(1,0,0,8'h01,0, 3'd6,N,  3'b000,0,2'b10,0);
        // mem_ready on the limit cycle wins
        for (int k = 0; k < 14; k++) add(0,0,0,8'h01,0, 3'd1,MRD,3'b000,0,2'b00,0);
        add(0,0,1,8'h01,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'h01,0, 3'd2,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'h01,0, 3'd3,N,  3'b000,1,2'b00,0);
        add(0,1,1,8'h01,0, 3'd5,RGW,3'b000,0,2'b00,1);
        add(0,0,1,8'h01,0, 3'd0,N,  3'b000,0,2'b00,0);
        // lead into EXEC of addi for the async reset check
        add(1,0,1,8'hA0,0, 3'd0,N,  3'b000,0,2'b00,0);
        add(0,0,1,8'hA0,0, 3'd1,FD, 3'b000,0,2'b00,0);
        add(0,0,1,8'hA0,0, 3'd2,N,  3'b000,0,2'b00,0);
        run_table();

        // now in EXEC: reset must act immediately
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || {ir_write, pc_write, pc_branch, mem_read, mem_write, reg_write, alu_src_b} !== 7'd0
            || alu_op !== 3'd0 || alu_funct !== 1'b0 || fault !== 2'd0 || retired !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d op=%b fault=%b retired=%0d, want st=0 op=000 fault=00 retired=0",
                     state, alu_op, fault, retired);
        end
        rc = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 256 beq retirements wrap the counter to 0
        add(1,0,1,8'hC0,0, 3'd0,N,  3'b000,0,2'b00,0);
        for (int k = 0; k < 256; k++) begin
            add(0,0,1,8'hC0,0, 3'd1,FD, 3'b000,0,2'b00,0);
            add(0,0,1,8'hC0,0, 3'd2,N,  3'b000,0,2'b00,0);
            add(0,0,1,8'hC0,0, 3'd3,N,  3'b110,0,2'b00,1);
        end
        add(0,0,1,8'hC0,0, 3'd1,FD, 3'b000,0,2'b00,0);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
